// File: rtl/kpt_stream_out_pkg.sv
// Shared SIFT keypoint definitions.
//   KPT_HDR_TAG / KPT_TRAILER : framing words of the keypoint stream
//   KPT_ROW_W / KPT_COL_W     : default coordinate field widths
//   kpt_entry_t / kpt_pack    : keypoint memory entry packing {row, col}
//   kpt_state_t               : readout FSM state encoding
//   kpt_clamp                 : saturate a 16-bit count at a maximum
package kpt_stream_out_pkg;

  localparam logic [15:0] KPT_HDR_TAG = 16'hF000;
  localparam logic [15:0] KPT_TRAILER = 16'hFFFF;
  localparam int          KPT_ROW_W   = 9;
  localparam int          KPT_COL_W   = 10;

  typedef struct packed {
    logic [KPT_ROW_W-1:0] row;
    logic [KPT_COL_W-1:0] col;
  } kpt_entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CNT, S_RD, S_LAT, S_ROW, S_COL, S_TRL, S_FIN
  } kpt_state_t;

  function automatic kpt_entry_t kpt_pack(input logic [KPT_ROW_W-1:0] row,
                                          input logic [KPT_COL_W-1:0] col);
    kpt_entry_t e;
    e.row = row;
    e.col = col;
    return e;
  endfunction

  function automatic logic [15:0] kpt_clamp(input logic [15:0] cnt,
                                            input int unsigned max_kpt);
    return (32'(cnt) > max_kpt) ? 16'(max_kpt) : cnt;
  endfunction

endpackage

// File: rtl/kpt_stream_out.sv
// Keypoint readout engine: after detection, walks the per-layer keypoint
// memories in ascending layer order and serialises them on a 16-bit stream.
// Per layer: header (F000|L), clamped count, then row/col word per entry.
// A trailer (FFFF) closes the stream.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse, sampled only in IDLE
//   kpt_count         NUM_LAYERS x 16-bit entry counts, layer 0 in LSBs
//   mem_rd_en/_layer/_addr, mem_rd_data  keypoint memory read port
//                     (data valid one cycle after mem_rd_en)
//   out_valid, out_data, out_ready  output stream
//   busy, done        status; done pulses once after the trailer is taken
//   o_dbg_state       current FSM state
//
// Stream handshake: a word transfers on a cycle where out_valid && out_ready.
// Once out_valid is raised, out_valid and out_data stay unchanged until that
// transfer happens. Both come straight from flops; out_ready only steers the
// next-state logic.
module kpt_stream_out
  import kpt_stream_out_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int MAX_KPT    = 2000,
  parameter int ROW_W      = KPT_ROW_W,
  parameter int COL_W      = KPT_COL_W,
  parameter int ADDR_W     = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_LAYERS*16-1:0]  kpt_count,
  output logic                      mem_rd_en,
  output logic [3:0]                mem_rd_layer,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [ROW_W+COL_W-1:0]    mem_rd_data,
  output logic                      out_valid,
  output logic [15:0]               out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                o_dbg_state
);

  localparam int         ENT_W      = ROW_W + COL_W;
  localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);

  kpt_state_t               r_state, w_state_nxt;
  logic [3:0]               r_layer, w_layer_nxt;
  logic [ADDR_W-1:0]        r_idx, w_idx_nxt;
  logic [NUM_LAYERS*16-1:0] r_counts;
  logic [ENT_W-1:0]         r_entry, w_entry;
  logic                     r_out_valid, w_out_valid_nxt;
  logic [15:0]              r_out_data, w_out_data_nxt;
  logic                     r_rd_en, w_rd_en_nxt;
  logic [3:0]               r_rd_layer;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;

  logic                     w_hs, w_is_last, w_more_ent;
  logic                     w_adv_layer, w_adv_entry;
  logic [15:0]              w_cur_count;

  assign w_hs        = r_out_valid & out_ready;
  assign w_cur_count = r_counts[r_layer*16 +: 16];
  assign w_is_last   = (r_layer == LAST_LAYER);
  assign w_more_ent  = (17'(r_idx) + 17'd1) < {1'b0, w_cur_count};

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_layer     <= '0;
      r_idx       <= '0;
      r_counts    <= '0;
      r_entry     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_rd_en     <= 1'b0;
      r_rd_layer  <= '0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_layer     <= w_layer_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      if (r_state == S_IDLE && start) begin
        for (int l = 0; l < NUM_LAYERS; l++)
          r_counts[l*16 +: 16] <= kpt_clamp(kpt_count[l*16 +: 16], MAX_KPT);
      end
      if (r_state == S_LAT) r_entry <= mem_rd_data;
      if (w_rd_en_nxt) begin
        r_rd_layer <= w_layer_nxt;
        r_rd_addr  <= w_idx_nxt;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_adv_layer = 1'b0;
    w_adv_entry = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_HDR;
      S_HDR:  if (w_hs) w_state_nxt = S_CNT;
      S_CNT: begin
        if (w_hs) begin
          if (w_cur_count != 16'd0) w_state_nxt = S_RD;
          else if (w_is_last)       w_state_nxt = S_TRL;
          else begin
            w_state_nxt = S_HDR;
            w_adv_layer = 1'b1;
          end
        end
      end
      S_RD:  w_state_nxt = S_LAT;
      S_LAT: w_state_nxt = S_ROW;
      S_ROW: if (w_hs) w_state_nxt = S_COL;
      S_COL: begin
        if (w_hs) begin
          if (w_more_ent) begin
            w_state_nxt = S_RD;
            w_adv_entry = 1'b1;
          end else if (w_is_last) w_state_nxt = S_TRL;
          else begin
            w_state_nxt = S_HDR;
            w_adv_layer = 1'b1;
          end
        end
      end
      S_TRL:   if (w_hs) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode. Outputs are registered, so they are computed from the
  // state being entered. The row word is produced while leaving LAT, before
  // r_entry has captured the read data, so it comes from mem_rd_data there.
  always_comb begin
    w_layer_nxt = r_layer;
    w_idx_nxt   = r_idx;
    if (r_state == S_IDLE) begin
      w_layer_nxt = '0;
      w_idx_nxt   = '0;
    end else if (w_adv_layer) begin
      w_layer_nxt = r_layer + 4'd1;
      w_idx_nxt   = '0;
    end else if (w_adv_entry) begin
      w_idx_nxt   = r_idx + ADDR_W'(1);
    end

    w_entry = (r_state == S_LAT) ? mem_rd_data : r_entry;

    w_out_valid_nxt = 1'b0;
    w_out_data_nxt  = '0;
    case (w_state_nxt)
      S_HDR: begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = KPT_HDR_TAG | {12'd0, w_layer_nxt};
      end
      S_CNT: begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_cur_count;
      end
      S_ROW: begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = 16'(w_entry[ENT_W-1:COL_W]);
      end
      S_COL: begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = 16'(w_entry[COL_W-1:0]);
      end
      S_TRL: begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = KPT_TRAILER;
      end
      default: ;
    endcase

    w_rd_en_nxt = (w_state_nxt == S_RD);
    w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
    w_done_nxt  = (w_state_nxt == S_FIN);
  end

  assign mem_rd_en    = r_rd_en;
  assign mem_rd_layer = r_rd_layer;
  assign mem_rd_addr  = r_rd_addr;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_kpt_stream_out.sv
module tb_kpt_stream_out;
  import kpt_stream_out_pkg::*;

  localparam int NL   = 2;
  localparam int MAXK = 2000;
  localparam int RW   = 9;
  localparam int CW   = 10;
  localparam int AW   = 11;
  localparam int EW   = RW + CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [NL*16-1:0] kpt_count = '0;
  logic            mem_rd_en;
  logic [3:0]      mem_rd_layer;
  logic [AW-1:0]   mem_rd_addr;
  logic [EW-1:0]   mem_rd_data = '0;
  logic            out_valid;
  logic [15:0]     out_data;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            done;
  logic [3:0]      o_dbg_state;

  kpt_stream_out #(
    .NUM_LAYERS(NL), .MAX_KPT(MAXK), .ROW_W(RW), .COL_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kpt_count(kpt_count),
    .mem_rd_en(mem_rd_en), .mem_rd_layer(mem_rd_layer),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- keypoint memory model (1-cycle read latency) -------
  logic [EW-1:0] mem [NL][2048];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_layer[0]][mem_rd_addr];
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [14:0] rd_q[$];
  logic [15:0] got_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int words_seen, rd_count, last_addr, done_count;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference stream built directly from the framing rules.
  task automatic build_model(input int c0, input int c1);
    int cnt [NL];
    int n;
    exp_q.delete(); rd_q.delete(); got_q.delete();
    words_seen = 0; rd_count = 0; last_addr = -1; done_count = 0;
    cnt[0] = c0; cnt[1] = c1;
    for (int l = 0; l < NL; l++) begin
      n = (cnt[l] > MAXK) ? MAXK : cnt[l];
      exp_q.push_back(16'(32'hF000 + l));
      exp_q.push_back(16'(n));
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(16'(int'(mem[l][i]) / (1 << CW)));
        exp_q.push_back(16'(int'(mem[l][i]) % (1 << CW)));
        rd_q.push_back(15'(l * 2048 + i));
      end
    end
    exp_q.push_back(16'hFFFF);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        words_seen++;
        got_q.push_back(out_data);
        if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 32'd1);
        else check("word", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (mem_rd_en) begin
        rd_count++;
        last_addr = int'(mem_rd_addr);
        if (rd_q.size() == 0) check("extra_read", 32'(rd_q.size()), 32'd1);
        else check("read_layer_addr", 32'({mem_rd_layer, mem_rd_addr}), 32'(rd_q.pop_front()));
      end
      if (done) begin
        done_count++;
        check("done_busy_low", 32'(busy), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int c0, input int c1);
    @(posedge clk); #1;
    kpt_count = {16'(c1), 16'(c0)};
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kpt_count = $urandom;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_done(input bit rnd_ready, input bit start_mid);
    int cyc = 0;
    while (done_count == 0 && cyc < 30000) begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_mid) start = (cyc == 0);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(done_count != 0), 32'd1);
    repeat (6) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("done_once", 32'(done_count), 32'd1);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(rd_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    int c0;
    int c1;
    bit rnd;
    int exp_words;
    int exp_reads;
    int exp_last;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] basic_words [11];

  initial begin
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < 2048; i++) mem[l][i] = EW'($urandom);
    mem[0][0] = kpt_pack(9'd5, 10'd7);
    mem[1][0] = kpt_pack(9'd9, 10'd639);
    mem[1][1] = kpt_pack(9'd479, 10'd0);

    vecs[0] = '{1, 2, 1'b0, 11, 3, 1};
    vecs[1] = '{0, 1, 1'b0, 7, 1, 0};
    vecs[2] = '{50, 0, 1'b1, 105, 50, 49};
    vecs[3] = '{2500, 0, 1'b0, 4005, 2000, 1999};
    vecs[4] = '{0, 0, 1'b1, 5, 0, -1};

    basic_words = '{16'hF000, 16'h0001, 16'h0005, 16'h0007, 16'hF001, 16'h0002,
                    16'h0009, 16'h027F, 16'h01DF, 16'h0000, 16'hFFFF};

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic stream, exact word list
    build_model(1, 2);
    pulse_start(1, 2);
    wait_done(1'b0, 1'b0);
    check("basic_len", 32'(got_q.size()), 32'd11);
    for (int i = 0; i < 11 && i < got_q.size(); i++)
      check("basic_word", 32'(got_q[i]), 32'(basic_words[i]));

    // table of streams
    for (int v = 0; v < 5; v++) begin
      build_model(vecs[v].c0, vecs[v].c1);
      pulse_start(vecs[v].c0, vecs[v].c1);
      wait_done(vecs[v].rnd, 1'b0);
      check("vec_words", 32'(words_seen), 32'(vecs[v].exp_words));
      check("vec_reads", 32'(rd_count), 32'(vecs[v].exp_reads));
      check("vec_last_addr", 32'(last_addr), 32'(vecs[v].exp_last));
    end

    // random streams under random backpressure
    for (int r = 0; r < 6; r++) begin
      int c0, c1;
      c0 = $urandom_range(0, 20);
      c1 = $urandom_range(0, 20);
      build_model(c0, c1);
      pulse_start(c0, c1);
      wait_done(1'b1, 1'b0);
    end

    // start while busy (pulse lands while the count word is presented)
    build_model(2, 3);
    pulse_start(2, 3);
    wait_done(1'b0, 1'b1);
    check("startbusy_words", 32'(words_seen), 32'd15);

    // reset mid-stream while a row word is presented
    begin
      bit found = 1'b0;
      build_model(3, 1);
      pulse_start(3, 1);
      for (int c = 0; c < 50 && !found; c++) begin
        @(posedge clk); #1;
        out_ready = 1'b1;
        if (o_dbg_state == 4'(S_ROW)) found = 1'b1;
      end
      check("reach_row", 32'(found), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_rd_en", 32'(mem_rd_en), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_done", 32'(done_count), 32'd0);
      build_model(3, 1);
      pulse_start(3, 1);
      wait_done(1'b0, 1'b0);
      check("replay_first", 32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'hF000);
      check("replay_words", 32'(words_seen), 32'd13);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kpt_stream_out.md
Name: kpt_stream_out

Overview:
- Keypoint readout engine for the SIFT core.
- After detection completes, it walks the per-layer keypoint memories in order and serialises every entry onto the core's 16-bit out_valid/out_data port.
- Generalised over layer count, memory depth and coordinate widths. Adds downstream backpressure (out_ready), per-layer framing and count clamping.

Parameters:
- NUM_LAYERS, 2, number of keypoint memories (DoG layers) streamed, 1..15
- MAX_KPT, 2000, entries per keypoint memory; counts above this are clamped
- ROW_W, 9, row field width; entry bits [ROW_W+COL_W-1:COL_W]
- COL_W, 10, column field width; entry bits [COL_W-1:0]
- ADDR_W, 11, keypoint memory address width, must satisfy 2^ADDR_W >= MAX_KPT

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin streaming (typically detect_filter_done)
- kpt_count  in  NUM_LAYERS*16  per-layer valid entry counts, layer 0 in LSBs; sampled on start
- mem_rd_en  out  1  keypoint memory read strobe
- mem_rd_layer  out  4  layer select for the read
- mem_rd_addr  out  ADDR_W  entry address
- mem_rd_data  in  ROW_W+COL_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  output word valid
- out_data  out  16  output word
- out_ready  in  1  downstream accepts the word when out_valid && out_ready
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the trailer is accepted

Behaviour:
- Reset: clk and rst_n only; reset is synchronous, active-low. All outputs reset to 0, FSM returns to IDLE, counters cleared. Reset applied mid-stream aborts the stream; no done is issued.
- Stream format per layer L, in ascending L:
  - header 16'hF000 | L
  - count word = min(kpt_count[L], MAX_KPT)
  - then per entry: row word (row zero-extended to 16 bits), then column word (col zero-extended).
- After the last layer: trailer 16'hFFFF.
- FSM states: IDLE, HDR, CNT, RD, LAT, ROW, COL, TRL, FIN.
  - IDLE: start is sampled. At cycle t+1 the FSM is in HDR and out_valid=1.
  - HDR -> CNT on handshake.
  - CNT -> RD on handshake if count>0. Otherwise go to HDR of the next layer, or to TRL if this was the last layer.
  - RD: mem_rd_en=1 for exactly one cycle, with addr = entry index and layer = L. out_valid=0.
  - LAT: latch mem_rd_data into the entry register. out_valid=0.
  - ROW -> COL on handshake.
  - COL on handshake:
    - if more entries remain in the layer: index+1, go to RD
    - else if more layers remain: go to HDR of the next layer
    - else: go to TRL.
  - TRL -> FIN on handshake.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- Handshake rules:
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
- Throughput: 2 entry words per 4 cycles with out_ready held high.
- start while busy: ignored. kpt_count is only sampled in IDLE.
- Counts are 16-bit unsigned and clamped to MAX_KPT at sampling. The entry index never exceeds MAX_KPT-1.
- Outputs are registered: out_valid and out_data come from flops, with no combinational path from out_ready.

Decomposition:
- Shared SIFT package holds:
  - KPT_HDR_TAG (16'hF000)
  - KPT_TRAILER (16'hFFFF)
  - ROW_W/COL_W defaults (9/10)
  - the keypoint entry packing {row, col}
  - the FSM state enumeration.
- No sub-module required. Optionally factor an output register slice (kpt_out_reg) holding out_valid/out_data under backpressure.

Test Plan:
- Basic stream: NUM_LAYERS=2, counts {1,2}, out_ready=1. Layer 0 holds entry {row=5, col=7}; layer 1 holds entries {row=9, col=639} and {row=479, col=0}. Required words: F000, 0001, 0005, 0007, F001, 0002, 0009, 027F, 01DF, 0000, FFFF. Then done is pulsed.
- Empty layer: counts {0,1}. Required: F000, 0000, F001, 0001, then the two words of the entry, then FFFF. No mem_rd_en is issued for layer 0.
- Backpressure: toggle out_ready 1/0 randomly over a 50-entry stream. The accepted word sequence is unchanged, and out_data is stable during every stall.
- Clamp: count 16'd2500 with MAX_KPT=2000. The count word is 07D0 and the last address read is 1999.
- Reset mid-stream: assert rst_n=0 while in ROW. Next cycle out_valid=0, busy=0, done=0. A fresh start then replays from the layer 0 header.
- Start while busy: pulse start during CNT. The stream and counts are unaffected, and exactly one done pulse is issued.
